parity_mem_scrub: RTL and testbench
===================================

PARITY_MEM_SCRUB -- requirements
Module: parity_mem_scrub

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ODD_PARITY, default 1, 1 = odd parity stored (bit = ~^data), 0 = even (bit = ^data).
REQ-004 SHALL have parameter SCRUB_EN, default 1, 1 = background scrubber active.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port: write  in  1  write request.
REQ-008 SHALL have port: read  in  1  read request.
REQ-009 SHALL have port: address  in  ADDR_W  access address.
REQ-010 SHALL have port: data_in  in  DATA_W  write data.
REQ-011 SHALL have port: inj_err  in  1  when high with write, stored parity bit inverted (test hook).
REQ-012 SHALL have port: data_out  out  DATA_W+1  {parity, data} read result.
REQ-013 SHALL have port: rd_valid  out  1  one-cycle pulse, data_out valid.
REQ-014 SHALL have port: busy  out  1  high during init sweep; requests ignored.
REQ-015 SHALL have port: par_err  out  1  one-cycle pulse on parity mismatch (user read or scrub).
REQ-016 SHALL have port: err_addr  out  ADDR_W  address of most recent mismatch, held.
REQ-017 SHALL have port: err_count  out  16  mismatch count, saturating.

Function
REQ-018 FSM states: INIT, RUN; rst -> INIT; INIT -> RUN after last location written; RUN has no exit except rst.
REQ-019 INIT: writes {parity(0), 0} to one location per cycle, address 0 upward; duration exactly 2**ADDR_W cycles; busy=1 throughout, 0 the cycle RUN is entered.
REQ-020 Write (RUN): stores {parity(data_in) ^ inj_err, data_in} at address on the same edge.
REQ-021 Read (RUN): data_out and rd_valid registered, latency 1 cycle; data_out holds until next read.
REQ-022 write and read same cycle: write performed, read dropped, rd_valid stays 0.
REQ-023 Requests during INIT: ignored, no memory change, rd_valid stays 0.
REQ-024 Parity check on every read: stored parity != parity(stored data) -> par_err pulse aligned with rd_valid, err_addr = read address.
REQ-025 Scrubber (SCRUB_EN=1): in RUN cycles with no write/read, reads location scrub_ptr, checks parity, increments scrub_ptr; wraps 2**ADDR_W-1 -> 0.
REQ-026 Scrub mismatch: par_err pulses 1 cycle after scrub read, err_addr = scrubbed address; rd_valid not asserted; data not modified.
REQ-027 User request in any cycle pre-empts scrub; scrub_ptr holds that cycle.
REQ-028 err_count increments by 1 per par_err pulse; saturates at 16'hFFFF.
REQ-029 Simultaneous user and scrub mismatch impossible by REQ-027; one pulse per cycle maximum.
REQ-030 SCRUB_EN=0: scrub logic absent; par_err only from user reads.

Reset
REQ-031 rst at any time, including mid-INIT or mid-read: next cycle state=INIT, sweep restarts at 0, scrub_ptr=0.
REQ-032 Reset values: data_out=0, rd_valid=0, par_err=0, err_addr=0, err_count=0, busy=1.

Structure
REQ-033 Shared package parity_pkg SHALL hold state typedef (INIT, RUN), parity function taking value and ODD_PARITY, and default parameter constants.
REQ-034 One sub-module par_calc (combinational parity generate/check, parametrised DATA_W, ODD_PARITY), instanced for write path and check path.
REQ-035 Memory array SHALL be one (DATA_W+1) x 2**ADDR_W register array inside parity_mem_scrub.

Verification (ADDR_W=4, DATA_W=8, ODD_PARITY=1)
REQ-036 rst then idle -> busy high 16 cycles, then 0; read addr 5 -> data_out=9'h100, rd_valid after 1 cycle.
REQ-037 Write 8'hA5 @3, 8'h07 @4, read both -> 9'h1A5 then 9'h007, par_err=0, err_count=0.
REQ-038 write 8'h3C @9 with inj_err=1, read @9 -> data_out=9'h03C, par_err pulse, err_addr=9, err_count=1.
REQ-039 Same injected fault, then idle >=16 cycles -> scrub par_err with err_addr=9, err_count increments once per 16-cycle pass, rd_valid stays 0.
REQ-040 write+read same cycle @2 with 8'hFF -> rd_valid=0; later read @2 = 9'h1FF.
REQ-041 Assert rst at cycle 7 of INIT -> busy remains high 16 further cycles, err_count=0, all outputs at reset values.

Source files
------------

// File: rtl/parity_pkg.sv
// ============================================================================
// Module  : parity_pkg
// Brief   : Shared state type, parity helper and default sizing constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    localparam int c_DEF_DATA_W     = 8;
    localparam int c_DEF_ADDR_W     = 16;
    localparam int c_DEF_ODD_PARITY = 1;
    localparam int c_DEF_SCRUB_EN   = 1;
    localparam int c_MAX_W          = 64;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Zero-extension to c_MAX_W leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [c_MAX_W-1:0] value,
                                         input logic               odd);
        return odd ? ~(^value) : (^value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/par_calc.sv
// ============================================================================
// Module  : par_calc
// Brief   : Combinational parity generate/check: o_par = parity(i_data) ^ i_par.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module par_calc
    import parity_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ODD_PARITY = c_DEF_ODD_PARITY
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par,
    output logic              o_par
);

    // Generate: i_par is a flip mask. Check: i_par is the stored bit and
    // o_par goes high on mismatch.
    assign o_par = calc_parity(c_MAX_W'(i_data), (ODD_PARITY != 0)) ^ i_par;

endmodule

`default_nettype wire

// File: rtl/parity_mem_scrub.sv
// ============================================================================
// Module  : parity_mem_scrub
// Brief   : Parity-protected register memory with init sweep and scrubber.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_mem_scrub
    import parity_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int ODD_PARITY = c_DEF_ODD_PARITY,
    parameter int SCRUB_EN   = c_DEF_SCRUB_EN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inj_err,
    output logic [DATA_W:0]   data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              par_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_count
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic              c_INIT_PAR  = calc_parity('0, (ODD_PARITY != 0));

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_ptr;
    logic [ADDR_W-1:0]   w_init_ptr_nxt;
    logic                w_run;

    logic [DATA_W:0]     r_mem [2**ADDR_W];

    logic                w_user_wr;
    logic                w_user_rd;
    logic                w_scrub_go;
    logic [ADDR_W-1:0]   w_scrub_ptr;
    logic                w_wr_par;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W:0]     w_wr_word;
    logic [ADDR_W-1:0]   w_chk_addr;
    logic [DATA_W:0]     w_chk_word;
    logic                w_chk_err;
    logic                w_chk_en;

    logic [DATA_W:0]     r_data_out;
    logic                r_rd_valid;
    logic                r_par_err;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [15:0]         r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        busy           = 1'b0;
        w_run          = 1'b0;
        case (r_state)
            INIT: begin
                busy           = 1'b1;
                w_init_ptr_nxt = r_init_ptr + 1'b1;
                if (r_init_ptr == c_LAST_ADDR) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // A simultaneous write wins and the read is dropped.
    assign w_user_wr = w_run & write;
    assign w_user_rd = w_run & read & ~write;

    par_calc #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_wr_par (
        .i_data (data_in),
        .i_par  (inj_err),
        .o_par  (w_wr_par)
    );

    assign w_mem_we   = busy | w_user_wr;
    assign w_mem_addr = busy ? r_init_ptr : address;
    assign w_wr_word  = busy ? {c_INIT_PAR, {DATA_W{1'b0}}} : {w_wr_par, data_in};

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_wr_word;
        end
    end

    generate
        if (SCRUB_EN != 0) begin : g_scrub_on
            logic [ADDR_W-1:0] r_scrub_ptr;

            assign w_scrub_go  = w_run & ~write & ~read;
            assign w_scrub_ptr = r_scrub_ptr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_scrub_ptr <= '0;
                end else if (w_scrub_go) begin
                    r_scrub_ptr <= r_scrub_ptr + 1'b1;
                end
            end
        end else begin : g_scrub_off
            assign w_scrub_go  = 1'b0;
            assign w_scrub_ptr = '0;
        end
    endgenerate

    // One shared check port: user reads and scrubs never occur together.
    assign w_chk_addr = w_user_rd ? address : w_scrub_ptr;
    assign w_chk_word = r_mem[w_chk_addr];
    assign w_chk_en   = w_user_rd | w_scrub_go;

    par_calc #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_chk_par (
        .i_data (w_chk_word[DATA_W-1:0]),
        .i_par  (w_chk_word[DATA_W]),
        .o_par  (w_chk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_par_err   <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_rd_valid <= w_user_rd;
            r_par_err  <= w_chk_en & w_chk_err;
            if (w_user_rd) begin
                r_data_out <= w_chk_word;
            end
            if (w_chk_en && w_chk_err) begin
                r_err_addr <= w_chk_addr;
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign rd_valid  = r_rd_valid;
    assign par_err   = r_par_err;
    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_parity_mem_scrub.sv
// ============================================================================
// Module  : tb_parity_mem_scrub
// Brief   : Directed self-checking bench for parity_mem_scrub (ADDR_W=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_mem_scrub;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 4;

    logic                clk;
    logic                rst;
    logic                write;
    logic                read;
    logic [c_ADDR_W-1:0] address;
    logic [c_DATA_W-1:0] data_in;
    logic                inj_err;
    logic [c_DATA_W:0]   data_out;
    logic                rd_valid;
    logic                busy;
    logic                par_err;
    logic [c_ADDR_W-1:0] err_addr;
    logic [15:0]         err_count;

    int vectors     = 0;
    int miscompares = 0;

    parity_mem_scrub #(
        .DATA_W     (c_DATA_W),
        .ADDR_W     (c_ADDR_W),
        .ODD_PARITY (1),
        .SCRUB_EN   (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .read      (read),
        .address   (address),
        .data_in   (data_in),
        .inj_err   (inj_err),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .par_err   (par_err),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data_out"},  32'(data_out),  32'h0);
        chk({tag, "_rd_valid"},  32'(rd_valid),  32'h0);
        chk({tag, "_par_err"},   32'(par_err),   32'h0);
        chk({tag, "_err_addr"},  32'(err_addr),  32'h0);
        chk({tag, "_err_count"}, 32'(err_count), 32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_hi;
        int pulses;
        int rv_pulses;
        int bad_addr;

        rst     = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        address = '0;
        data_in = '0;
        inj_err = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");

        // Requests during INIT must be ignored, then reset at INIT cycle 7.
        rst = 1'b0;
        repeat (3) tick();
        read    = 1'b1;
        address = 4'd0;
        tick();
        chk("init_read0_rd_valid", 32'(rd_valid), 32'h0);
        tick();
        chk("init_read1_rd_valid", 32'(rd_valid), 32'h0);
        read    = 1'b0;
        write   = 1'b1;
        data_in = 8'hAA;
        inj_err = 1'b1;
        tick();
        chk("init_write_rd_valid", 32'(rd_valid), 32'h0);
        tick();
        write   = 1'b0;
        inj_err = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("midinit_reset");

        busy_hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1) busy_hi++;
            tick();
        end
        chk("busy_high_cycles", 32'(busy_hi), 32'd16);
        chk("busy_low_in_run", 32'(busy), 32'h0);

        // Fresh location reads back {odd parity of 0, 0}.
        read    = 1'b1;
        address = 4'd5;
        tick();
        read = 1'b0;
        chk("read5_rd_valid", 32'(rd_valid), 32'h1);
        chk("read5_data",     32'(data_out), 32'h100);
        chk("read5_par_err",  32'(par_err),  32'h0);
        tick();
        chk("read5_rd_valid_drop", 32'(rd_valid), 32'h0);
        chk("read5_data_hold",     32'(data_out), 32'h100);

        read    = 1'b1;
        address = 4'd0;
        tick();
        read = 1'b0;
        chk("read0_after_init_write", 32'(data_out), 32'h100);

        write   = 1'b1;
        address = 4'd3;
        data_in = 8'hA5;
        tick();
        address = 4'd4;
        data_in = 8'h07;
        tick();
        write   = 1'b0;
        read    = 1'b1;
        address = 4'd3;
        tick();
        chk("read3_data",    32'(data_out), 32'h1A5);
        chk("read3_par_err", 32'(par_err),  32'h0);
        address = 4'd4;
        tick();
        read = 1'b0;
        chk("read4_data",      32'(data_out),  32'h007);
        chk("read4_par_err",   32'(par_err),   32'h0);
        chk("read4_err_count", 32'(err_count), 32'h0);

        write   = 1'b1;
        read    = 1'b1;
        address = 4'd2;
        data_in = 8'hFF;
        tick();
        write = 1'b0;
        read  = 1'b0;
        chk("wr_rd_same_rd_valid", 32'(rd_valid), 32'h0);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("read2_rd_valid", 32'(rd_valid), 32'h1);
        chk("read2_data",     32'(data_out), 32'h1FF);

        write   = 1'b1;
        address = 4'd9;
        data_in = 8'h3C;
        inj_err = 1'b1;
        tick();
        write   = 1'b0;
        inj_err = 1'b0;
        read    = 1'b1;
        tick();
        read = 1'b0;
        chk("read9_data",      32'(data_out),  32'h03C);
        chk("read9_par_err",   32'(par_err),   32'h1);
        chk("read9_err_addr",  32'(err_addr),  32'h9);
        chk("read9_err_count", 32'(err_count), 32'h1);

        // 32 idle cycles = two full scrub passes, each hitting address 9 once.
        pulses    = 0;
        rv_pulses = 0;
        bad_addr  = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (par_err === 1'b1) begin
                pulses++;
                if (err_addr !== 4'd9) bad_addr++;
            end
            if (rd_valid === 1'b1) rv_pulses++;
        end
        chk("scrub_pulses",    32'(pulses),    32'd2);
        chk("scrub_rd_valid",  32'(rv_pulses), 32'd0);
        chk("scrub_err_addr",  32'(bad_addr),  32'd0);
        chk("scrub_err_count", 32'(err_count), 32'd3);
        chk("scrub_data_hold", 32'(data_out),  32'h03C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
